// File: rtl/csa_merge_adder.sv
// Sequential final carry-propagate adder: resolves CSA sum/carry vectors one CHUNK slice per cycle.
// Optional early termination when the remaining operand bits and carry are all zero: CSA_MERGE_EARLY_EN.
module csa_merge_adder #(
    parameter int WIDTH = 288,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK + 1) : 1;
    localparam int OW     = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, c_q;
    logic [WIDTH:0]   result_q;
    logic [KW-1:0]    k_q;
    logic             cy_q;

    logic             accept;
    logic             last;
    logic             skip;
    logic [CHUNK:0]   slice;
    logic [OW-1:0]    base;

    // Operands are shifted down one slice per ADD cycle, so the low CHUNK bits
    // are always the current slice and the registers hold exactly s[WIDTH-1:k*CHUNK].
    assign slice  = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
    assign base   = OW'(int'(k_q) * CHUNK);
    assign last   = (k_q == LAST_K);
    assign accept = in_valid && (state_q == IDLE);

`ifdef CSA_MERGE_EARLY_EN
    assign skip = (s_q == '0) && (c_q == '0) && !cy_q;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ADD;
            end
            ADD: begin
                if (skip || last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            k_q      <= '0;
            cy_q     <= 1'b0;
        end else if (accept) begin
            s_q      <= sum_in;
            c_q      <= carry_in;
            result_q <= '0;
            k_q      <= '0;
            cy_q     <= 1'b0;
        end else if (state_q == ADD && !skip) begin
            result_q[base +: CHUNK] <= slice[CHUNK-1:0];
            if (last) result_q[WIDTH] <= slice[CHUNK];
            cy_q <= slice[CHUNK];
            s_q  <= s_q >> CHUNK;
            c_q  <= c_q >> CHUNK;
            k_q  <= k_q + 1'b1;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_csa_merge_adder.sv
// Self-checking bench for csa_merge_adder: randomized and directed operands, scoreboard
// queue filled by the driver and drained by an independent output monitor.
module tb_csa_merge_adder;

    localparam int W = 288;
    localparam int C = 32;
    localparam int N = W / C;
`ifdef CSA_MERGE_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum_in;
    logic [W-1:0] carry_in;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W:0]   result;

    always #5 clk = ~clk;

    csa_merge_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum_in   (sum_in),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    typedef struct {
        logic [W:0] res;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hs_cyc   = -1;
    int   rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference latency: slices stop early once the untouched high operand bits
    // are zero and no carry enters that slice from the arithmetic below it.
    function automatic int exp_lat(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W:0] mask;
        logic [W:0] lo;
        for (int k = 0; k < N; k++) begin
            mask = ({{W{1'b0}}, 1'b1} << (k * C)) - 1'b1;
            lo   = ({1'b0, s} & mask) + ({1'b0, c} & mask);
            if (EARLY && (s >> (k * C)) == '0 && (c >> (k * C)) == '0 && !lo[k*C]) return k + 1;
        end
        return N;
    endfunction

    // Output monitor
    logic prev_valid = 1'b0;
    bit   have_cur   = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            check("ready_valid_exclusive", {{W{1'b0}}, in_ready && out_valid}, '0);
            if (out_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected no output", result);
                end else begin
                    cur      = sb_q.pop_front();
                    have_cur = 1'b1;
                    check("result", result, cur.res);
                    check("latency", (W+1)'(cyc - cur.acc), (W+1)'(cur.lat));
                end
            end else if (out_valid && have_cur) begin
                check("result_hold", result, cur.res);
            end else if (out_valid) begin
                checks++;
                failures++;
                $display("FAIL stale_valid: got out_valid=1 expected 0 after handshake");
            end
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                hs_cyc   = cyc + 1;
                have_cur = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, output int acc);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
            acc = -1;
            return;
        end
        in_valid = 1'b1;
        sum_in   = s;
        carry_in = c;
        acc      = cyc + 1;
        e.res    = {1'b0, s} + {1'b0, c};
        e.acc    = acc;
        e.lat    = exp_lat(s, c);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sum_in   = rnd();
        carry_in = rnd();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0 || out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int acc2;
        int n;
        logic [W-1:0] s;
        logic [W-1:0] c;

        in_valid = 1'b0;
        sum_in   = '0;
        carry_in = '0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {{W{1'b0}}, in_ready}, 1);
        check("reset_out_valid", {{W{1'b0}}, out_valid}, 0);
        check("reset_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple across every slice
        send({W{1'b1}}, 1, acc);
        wait_idle();

        // Simple add followed immediately by a second operation
        send(W'(32'h1234_5678), 1, acc);
        send(rnd(), rnd(), acc2);
        check("b2b_accept_edge", (W+1)'(acc2), (W+1)'(hs_cyc + 1));
        wait_idle();

        // Backpressure with ignored in_valid pulses
        rdy_mode = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send(rnd(), rnd(), acc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid_rise", {{W{1'b0}}, out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            sum_in   = rnd();
            carry_in = rnd();
            check("bp_in_ready_low", {{W{1'b0}}, in_ready}, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_out_valid_held", {{W{1'b0}}, out_valid}, 1);
        rdy_mode = 0;
        wait_idle();

        // Asynchronous reset during the k = 4 slice
        send(rnd(), rnd(), acc);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", {{W{1'b0}}, in_ready}, 1);
        check("midreset_out_valid", {{W{1'b0}}, out_valid}, 0);
        check("midreset_result", result, '0);
        sb_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(5, 7, acc);
        wait_idle();

        // Zero operands and a short carry chain into slice 1
        send('0, '0, acc);
        wait_idle();
        send(W'(32'hFFFF_FFFF), 1, acc);
        wait_idle();

        // Randomized operations with random downstream backpressure
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: begin s = rnd(); c = rnd(); end
                1: begin
                    s = rnd() >> (32 * $urandom_range(1, N));
                    c = rnd() >> (32 * $urandom_range(1, N));
                end
                default: begin s = rnd(); c = ~s + 1'b1; end
            endcase
            send(s, c, acc);
        end
        rdy_mode = 0;
        wait_idle();
        check("scoreboard_empty", (W+1)'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
